// File: rtl/sort_pkg.sv
// Shared types and defaults for the bubble-sort engine host side.
package sort_pkg;

   localparam int unsigned SortK  = 8;
   localparam int unsigned SortDw = 8;

   typedef enum logic [2:0] {
      StLoad,
      StKick,
      StSort,
      StRead,
      StRelease
   } sort_host_state_t;

endpackage

// File: rtl/sort_idx_counter.sv
// AW-bit index counter with synchronous clear, enable and terminal flag at K-1.
// Wraps to zero when enabled at the terminal value.
module sort_idx_counter
   import sort_pkg::*;
#(
   parameter int unsigned K = SortK,
   localparam int unsigned AW = $clog2(K)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [AW-1:0] cnt_o,
   output logic          term_o
);

   logic [AW-1:0] cnt_q, cnt_d;

   assign term_o = (cnt_q == AW'(K - 1));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = term_o ? '0 : cnt_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sort_host_sequencer.sv
// Host-side scheduler for the bubble-sort engine: load K words, kick the sort, stream results out.
// Optional sort cycle counter output enabled by SORT_HOST_CYCLE_COUNT_EN.
module sort_host_sequencer
   import sort_pkg::*;
#(
   parameter int unsigned K  = SortK,
   parameter int unsigned DW = SortDw,
   parameter int unsigned CW = 16,
   localparam int unsigned AW = $clog2(K)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          in_valid_i,
   input  logic [DW-1:0] in_data_i,
   output logic          in_ready_o,
   output logic          out_valid_o,
   output logic [DW-1:0] out_data_o,
   output logic          out_last_o,
   input  logic          out_ready_i,
   output logic          sort_start_o,
   input  logic          sort_done_i,
   output logic          mem_sel_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic          mem_wr_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          busy_o
`ifdef SORT_HOST_CYCLE_COUNT_EN
   ,
   output logic [CW-1:0] sort_cycles_o
`endif
);

   sort_host_state_t state_q, state_d;
   logic [AW-1:0]    cnt;
   logic             cnt_term;
   logic             cnt_en;
   logic             cnt_clr;

   sort_idx_counter #(
      .K (K)
   ) u_idx (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt),
      .term_o (cnt_term)
   );

   // Index is already zero on entry to KICK/RELEASE; clearing there keeps it pinned.
   assign cnt_clr = (state_q == StKick) || (state_q == StRelease);
   assign busy_o  = (state_q != StLoad);

   always_comb begin
      state_d      = state_q;
      in_ready_o   = 1'b0;
      out_valid_o  = 1'b0;
      out_data_o   = '0;
      out_last_o   = 1'b0;
      sort_start_o = 1'b0;
      mem_sel_o    = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_wr_o     = 1'b0;
      cnt_en       = 1'b0;
      unique case (state_q)
         StLoad: begin
            in_ready_o  = 1'b1;
            mem_sel_o   = 1'b1;
            mem_addr_o  = cnt;
            mem_wdata_o = in_data_i;
            mem_wr_o    = in_valid_i;
            cnt_en      = in_valid_i;
            if (in_valid_i && cnt_term) state_d = StKick;
         end
         StKick: begin
            sort_start_o = 1'b1;
            state_d      = StSort;
         end
         StSort: begin
            if (sort_done_i) state_d = StRead;
         end
         StRead: begin
            mem_sel_o   = 1'b1;
            mem_addr_o  = cnt;
            out_valid_o = 1'b1;
            out_data_o  = mem_rdata_i;
            out_last_o  = cnt_term;
            cnt_en      = out_ready_i;
            if (out_ready_i && cnt_term) state_d = StRelease;
         end
         StRelease: begin
            // Second start pulse walks the sort controller from done back to idle.
            sort_start_o = 1'b1;
            mem_sel_o    = 1'b1;
            state_d      = StLoad;
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef SORT_HOST_CYCLE_COUNT_EN
   logic [CW-1:0] cyc_q, cyc_d;

   always_comb begin
      cyc_d = cyc_q;
      if (state_q == StKick) begin
         cyc_d = '0;
      end else if (state_q == StSort && cyc_q != '1) begin
         cyc_d = cyc_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign sort_cycles_o = cyc_q;
`else
   logic [CW-1:0] unused_cw;
   assign unused_cw = '0;
`endif

endmodule
